// File: rtl/spi_route_pkg.sv
// Shared types and helpers for the SPI source router: arbitration state and owner index width.
package spi_route_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWNED = 2'd1,
      DRAIN = 2'd2,
      GUARD = 2'd3
   } state_t;

   function automatic int owner_w(input int nsrc);
      return (nsrc > 1) ? $clog2(nsrc) : 1;
   endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-bit flop chain synchroniser with asynchronous reset to a chosen idle value.
module spi_sync #(
   parameter int               WIDTH   = 1,
   parameter int               DEPTH   = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else begin
         stage[0] <= d;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[DEPTH-1];

endmodule

// File: rtl/spi_route_mux.sv
// Routes one of NSRC SPI masters onto the shared core SPI bus; ownership moves only after
// the owner has been idle long enough, with a no-grant guard gap between owners.
module spi_route_mux
   import spi_route_pkg::*;
#(
   parameter int NSRC        = 2,
   parameter int SYNC_STAGES = 2,
   parameter int IDLE_CYC    = 8,
   parameter int GUARD_CYC   = 4,
   parameter bit CPOL        = 1'b0,
   parameter int LED_BITS    = 20
) (
   input  logic                     CLOCK_50,
   input  logic                     RESET,
   input  logic [NSRC-1:0]          src_ss_n,
   input  logic [NSRC-1:0]          src_sck,
   input  logic [NSRC-1:0]          src_mosi,
   output logic [NSRC-1:0]          src_miso,
   output logic [NSRC-1:0]          src_miso_oe,
   output logic                     bus_sck,
   output logic                     bus_mosi,
   output logic                     bus_ss_n,
   input  logic                     bus_miso,
   output logic [NSRC-1:0]          grant,
   output logic [$clog2(NSRC)-1:0]  owner,
   output logic                     busy,
   output logic                     led_n
);

   localparam int OW  = owner_w(NSRC);
   localparam int ICW = $clog2(IDLE_CYC + 1);
   localparam int GCW = $clog2(GUARD_CYC + 1);
   localparam logic [ICW-1:0] IDLE_LAST  = ICW'(IDLE_CYC - 1);
   localparam logic [GCW-1:0] GUARD_LAST = GCW'(GUARD_CYC - 1);

   state_t               state;
   logic [NSRC-1:0]      grant_r;
   logic [OW-1:0]        owner_r;
   logic                 busy_r;
   logic [ICW-1:0]       idle_cnt;
   logic [GCW-1:0]       guard_cnt;
   logic [LED_BITS-1:0]  led_cnt;

   logic [NSRC-1:0]      req_s;
   logic                 sck_mux;
   logic                 sck_s;
   logic                 sck_d;
   logic                 sck_edge;
   logic                 granted;
   logic                 req_any;
   logic [OW-1:0]        req_idx;
   logic [NSRC-1:0]      req_onehot;

   // Chip selects idle high, so the request chain resets to all-ones.
   spi_sync #(
      .WIDTH   (NSRC),
      .DEPTH   (SYNC_STAGES),
      .RST_VAL ({NSRC{1'b1}})
   ) u_req_sync (
      .clk (CLOCK_50),
      .rst (RESET),
      .d   (src_ss_n),
      .q   (req_s)
   );

   assign sck_mux = src_sck[owner_r];

   spi_sync #(
      .WIDTH   (1),
      .DEPTH   (SYNC_STAGES),
      .RST_VAL (CPOL)
   ) u_sck_sync (
      .clk (CLOCK_50),
      .rst (RESET),
      .d   (sck_mux),
      .q   (sck_s)
   );

   assign granted  = |grant_r;
   assign sck_edge = (sck_s != sck_d);

   // Descending scan leaves the lowest active-low request as the winner.
   always_comb begin
      req_any    = 1'b0;
      req_idx    = '0;
      req_onehot = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (!req_s[i]) begin
            req_any       = 1'b1;
            req_idx       = OW'(i);
            req_onehot    = '0;
            req_onehot[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         state     <= IDLE;
         grant_r   <= '0;
         owner_r   <= '0;
         busy_r    <= 1'b0;
         idle_cnt  <= '0;
         guard_cnt <= '0;
         sck_d     <= CPOL;
      end else begin
         sck_d <= sck_s;
         case (state)
            IDLE: begin
               if (req_any) begin
                  grant_r <= req_onehot;
                  owner_r <= req_idx;
                  busy_r  <= 1'b1;
                  state   <= OWNED;
               end
            end
            OWNED: begin
               if (req_s[owner_r]) begin
                  idle_cnt <= '0;
                  state    <= DRAIN;
               end
            end
            DRAIN: begin
               // Grant is held until SCK has sat at its idle level long enough.
               if (!req_s[owner_r]) begin
                  state <= OWNED;
               end else if ((sck_s != CPOL) || sck_edge) begin
                  idle_cnt <= '0;
               end else if (idle_cnt == IDLE_LAST) begin
                  grant_r   <= '0;
                  guard_cnt <= '0;
                  state     <= GUARD;
               end else begin
                  idle_cnt <= idle_cnt + ICW'(1);
               end
            end
            GUARD: begin
               if (guard_cnt == GUARD_LAST) begin
                  busy_r <= 1'b0;
                  state  <= IDLE;
               end else begin
                  guard_cnt <= guard_cnt + GCW'(1);
               end
            end
            default: begin
               grant_r <= '0;
               busy_r  <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   // Activity stretcher: reloads on every owner SCK edge, bleeds down to zero otherwise.
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         led_cnt <= '0;
      end else if (granted && sck_edge) begin
         led_cnt <= '1;
      end else if (led_cnt != '0) begin
         led_cnt <= led_cnt - LED_BITS'(1);
      end
   end

   assign bus_sck     = granted ? src_sck[owner_r]  : CPOL;
   assign bus_mosi    = granted ? src_mosi[owner_r] : 1'b0;
   assign bus_ss_n    = granted ? src_ss_n[owner_r] : 1'b1;
   assign src_miso    = {NSRC{bus_miso}} & grant_r;
   assign src_miso_oe = grant_r;

   assign grant = grant_r;
   assign owner = owner_r;
   assign busy  = busy_r;
   assign led_n = (led_cnt == '0);

endmodule

// File: tb/tb_spi_route_mux.sv
// Bench for spi_route_mux: directed scenarios plus random traffic against a behavioural model.
module tb_spi_route_mux;

   localparam int NSRC      = 2;
   localparam int SYNC      = 2;
   localparam int IDLE_CYC  = 8;
   localparam int GUARD_CYC = 4;
   localparam bit CPOL      = 1'b0;
   localparam int LED_BITS  = 4;
   localparam int OWB       = $clog2(NSRC);
   localparam int LED_MAX   = (1 << LED_BITS) - 1;

   logic             CLOCK_50 = 1'b0;
   logic             RESET;
   logic [NSRC-1:0]  ss_n;
   logic [NSRC-1:0]  sck;
   logic [NSRC-1:0]  mosi;
   logic             bus_miso;
   logic [NSRC-1:0]  src_miso;
   logic [NSRC-1:0]  src_miso_oe;
   logic             bus_sck;
   logic             bus_mosi;
   logic             bus_ss_n;
   logic [NSRC-1:0]  grant;
   logic [OWB-1:0]   owner;
   logic             busy;
   logic             led_n;

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   spi_route_mux #(
      .NSRC        (NSRC),
      .SYNC_STAGES (SYNC),
      .IDLE_CYC    (IDLE_CYC),
      .GUARD_CYC   (GUARD_CYC),
      .CPOL        (CPOL),
      .LED_BITS    (LED_BITS)
   ) dut (
      .CLOCK_50    (CLOCK_50),
      .RESET       (RESET),
      .src_ss_n    (ss_n),
      .src_sck     (sck),
      .src_mosi    (mosi),
      .src_miso    (src_miso),
      .src_miso_oe (src_miso_oe),
      .bus_sck     (bus_sck),
      .bus_mosi    (bus_mosi),
      .bus_ss_n    (bus_ss_n),
      .bus_miso    (bus_miso),
      .grant       (grant),
      .owner       (owner),
      .busy        (busy),
      .led_n       (led_n)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_gnt < 0 means nobody owns the bus; m_gap counts remaining guard cycles.
   int              m_gnt   = -1;
   int              m_owner = 0;
   int              m_quiet = 0;
   int              m_gap   = 0;
   int              m_led   = 0;
   bit              m_rel   = 1'b0;
   logic [NSRC-1:0] req_line [SYNC];
   logic            sck_line [SYNC];
   logic            sck_prev = CPOL;

   task automatic model_reset();
      for (int i = 0; i < SYNC; i++) begin
         req_line[i] = '1;
         sck_line[i] = CPOL;
      end
      sck_prev = CPOL;
      m_gnt    = -1;
      m_owner  = 0;
      m_quiet  = 0;
      m_gap    = 0;
      m_led    = 0;
      m_rel    = 1'b0;
   endtask

   task automatic model_step();
      logic [NSRC-1:0] rq;
      logic            sk;
      bit              sk_edge;
      int              old_owner;
      rq        = req_line[SYNC-1];
      sk        = sck_line[SYNC-1];
      sk_edge   = (sk != sck_prev);
      old_owner = m_owner;
      if (m_gnt >= 0 && sk_edge) m_led = LED_MAX;
      else if (m_led > 0) m_led--;
      if (m_gnt < 0) begin
         if (m_gap > 0) m_gap--;
         else begin
            for (int i = 0; i < NSRC; i++) begin
               if (!rq[i]) begin
                  m_gnt   = i;
                  m_owner = i;
                  break;
               end
            end
         end
      end else if (!m_rel) begin
         if (rq[m_gnt]) begin
            m_rel   = 1'b1;
            m_quiet = 0;
         end
      end else if (!rq[m_gnt]) begin
         m_rel = 1'b0;
      end else if (sk != CPOL || sk_edge) begin
         m_quiet = 0;
      end else if (m_quiet == IDLE_CYC - 1) begin
         m_gnt = -1;
         m_gap = GUARD_CYC;
         m_rel = 1'b0;
      end else begin
         m_quiet++;
      end
      sck_prev = sk;
      for (int i = SYNC - 1; i > 0; i--) begin
         req_line[i] = req_line[i-1];
         sck_line[i] = sck_line[i-1];
      end
      req_line[0] = ss_n;
      sck_line[0] = sck[old_owner];
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge CLOCK_50 or posedge RESET);
         if (RESET) model_reset();
         else model_step();
      end
   end

   task automatic compare_all();
      logic [NSRC-1:0] eg;
      eg = '0;
      if (m_gnt >= 0) eg[m_gnt] = 1'b1;
      check("grant",       32'(grant),       32'(eg));
      check("owner",       32'(owner),       32'(m_owner));
      check("busy",        32'(busy),        32'((m_gnt >= 0) || (m_gap > 0)));
      check("led_n",       32'(led_n),       32'(m_led == 0));
      check("bus_sck",     32'(bus_sck),     32'((m_gnt >= 0) ? sck[m_gnt]  : CPOL));
      check("bus_mosi",    32'(bus_mosi),    32'((m_gnt >= 0) ? mosi[m_gnt] : 1'b0));
      check("bus_ss_n",    32'(bus_ss_n),    32'((m_gnt >= 0) ? ss_n[m_gnt] : 1'b1));
      check("src_miso",    32'(src_miso),    32'(bus_miso ? eg : '0));
      check("src_miso_oe", 32'(src_miso_oe), 32'(eg));
   endtask

   initial begin
      forever begin
         @(negedge CLOCK_50);
         if (chk_on) compare_all();
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive_edge();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
   endtask

   initial begin
      ss_n     = '1;
      sck      = {NSRC{CPOL}};
      mosi     = '0;
      bus_miso = 1'b0;
      RESET    = 1'b0;
      #1 RESET = 1'b1;
      #2;
      check("rst_grant",    32'(grant),       32'(0));
      check("rst_busy",     32'(busy),        32'(0));
      check("rst_led_n",    32'(led_n),       32'(1));
      check("rst_bus_ss_n", 32'(bus_ss_n),    32'(1));
      check("rst_bus_sck",  32'(bus_sck),     32'(CPOL));
      check("rst_oe",       32'(src_miso_oe), 32'(0));
      chk_on = 1'b1;
      repeat (3) @(posedge CLOCK_50);
      #1 RESET = 1'b0;

      // no requests: bus stays parked
      wait_neg(20);
      check("idle_grant", 32'(grant), 32'(0));
      check("idle_led_n", 32'(led_n), 32'(1));

      // single request latency and MISO steering
      drive_edge();
      ss_n[1] = 1'b0;
      mosi    = 2'b10;
      wait_neg(2);
      check("lat_early", 32'(grant), 32'(0));
      wait_neg(1);
      check("lat_grant", 32'(grant), 32'(2'b10));
      drive_edge();
      bus_miso = 1'b1;
      @(negedge CLOCK_50);
      check("miso_route", 32'(src_miso),    32'(2'b10));
      check("miso_oe",    32'(src_miso_oe), 32'(2'b10));
      check("miso_ss",    32'(bus_ss_n),    32'(0));
      drive_edge();
      ss_n     = '1;
      bus_miso = 1'b0;
      wait_neg(30);
      check("rel1_grant", 32'(grant), 32'(0));

      // simultaneous requests, guard gap, handover
      drive_edge();
      ss_n = 2'b00;
      wait_neg(3);
      check("prio_grant", 32'(grant), 32'(2'b01));
      drive_edge();
      ss_n[0] = 1'b1;
      wait_neg(10);
      check("drain_hold", 32'(grant), 32'(2'b01));
      wait_neg(1);
      check("guard_start", 32'(grant), 32'(0));
      wait_neg(4);
      check("guard_end", 32'(grant), 32'(0));
      wait_neg(1);
      check("handover", 32'(grant), 32'(2'b10));
      drive_edge();
      ss_n = '1;
      wait_neg(30);

      // SS released but SCK keeps toggling every 5 cycles
      drive_edge();
      ss_n[0] = 1'b0;
      wait_neg(4);
      check("tog_own", 32'(grant), 32'(2'b01));
      for (int k = 0; k < 6; k++) begin
         drive_edge();
         sck[0] = ~sck[0];
         if (k == 0) ss_n[0] = 1'b1;
         if (k < 5) repeat (4) @(posedge CLOCK_50);
      end
      wait_neg(10);
      check("tog_hold", 32'(grant), 32'(2'b01));
      wait_neg(1);
      check("tog_drop", 32'(grant), 32'(0));
      wait_neg(30);

      // owner reasserts SS during drain while another source waits
      drive_edge();
      ss_n[0] = 1'b0;
      wait_neg(4);
      drive_edge();
      ss_n[1] = 1'b0;
      wait_neg(4);
      check("re_wait", 32'(grant), 32'(2'b01));
      drive_edge();
      ss_n[0] = 1'b1;
      wait_neg(4);
      drive_edge();
      ss_n[0] = 1'b0;
      wait_neg(20);
      check("re_grant", 32'(grant), 32'(2'b01));
      check("re_busy",  32'(busy),  32'(1));
      drive_edge();
      ss_n = '1;
      wait_neg(40);

      // asynchronous reset in the middle of a transfer
      drive_edge();
      ss_n[1] = 1'b0;
      wait_neg(5);
      check("mid_grant", 32'(grant), 32'(2'b10));
      drive_edge();
      sck[1] = 1'b1;
      drive_edge();
      RESET = 1'b1;
      #1;
      check("arst_grant", 32'(grant),       32'(0));
      check("arst_ss",    32'(bus_ss_n),    32'(1));
      check("arst_oe",    32'(src_miso_oe), 32'(0));
      drive_edge();
      sck[1] = CPOL;
      drive_edge();
      RESET = 1'b0;
      wait_neg(2);
      check("post_rst_early", 32'(grant), 32'(0));
      wait_neg(1);
      check("post_rst_grant", 32'(grant), 32'(2'b10));
      drive_edge();
      ss_n = '1;
      wait_neg(30);

      // random traffic
      for (int c = 0; c < 4000; c++) begin
         drive_edge();
         if (RESET) RESET = 1'b0;
         else if ($urandom_range(0, 999) == 0) RESET = 1'b1;
         for (int s = 0; s < NSRC; s++) begin
            if ($urandom_range(0, 19) == 0) ss_n[s] = ~ss_n[s];
            if (!ss_n[s]) begin
               if ($urandom_range(0, 2) == 0) sck[s] = ~sck[s];
            end else if ($urandom_range(0, 11) == 0) begin
               sck[s] = ~sck[s];
            end
         end
         mosi     = NSRC'($urandom);
         bus_miso = 1'($urandom);
      end
      drive_edge();
      RESET = 1'b0;
      ss_n  = '1;
      sck   = {NSRC{CPOL}};
      wait_neg(40);
      check("final_grant", 32'(grant), 32'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
